// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
//   NUM_IRQ  : number of request lines
//   IDX_W    : width of a request index
//   state_t  : handshake/service state of the controller
//   idx_onehot() : expands an index into a one-hot line mask
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [NUM_IRQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_IRQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc8_sel.sv
// Combinational 8->3 highest-bit selector.
//   req       in  8  candidate request lines
//   idx       out 3  index of the highest set bit of req (0 when none)
//   any_valid out 1  at least one bit of req is set
// Always-driven outputs; no enable input.
module prio_enc8_sel
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: rising edges on irq set bits in a pending register,
// a software mask filters eligibility, and the highest eligible index is
// offered over a valid/ready handshake, then held in service until eoi.
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   irq        in  8  request lines (rising edge sets pending)
//   mask_we    in  1  mask write strobe
//   mask_wdata in  8  new mask value (1 = line masked)
//   vec_valid  out 1  vec_idx is offered
//   vec_ready  in  1  consumer accepts the offered vector
//   vec_idx    out 3  offered index, 7 = highest priority
//   eoi        in  1  end-of-interrupt pulse
//   busy       out 1  an accepted request is in service
//   pending    out 8  pending register readback
// Optional build macro IRQ_SYNC_EN: adds a two-flop synchronizer on irq
// ahead of edge detection (irq-to-vec_valid latency grows from 2 to 4).
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter logic [NUM_IRQ-1:0] MASK_RST = 8'h00
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic [IDX_W-1:0]   vec_idx,
    input  logic               eoi,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic               accept;
    logic [IDX_W-1:0]   vec_idx_next;
    state_t             state;
    state_t             state_next;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_a;
    logic [NUM_IRQ-1:0] sync_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= irq;
            sync_b <= sync_a;
        end
    end

    assign irq_src = sync_b;
`else
    assign irq_src = irq;
`endif

    // irq_q resets low, so a line already high at reset release is an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_src;
        end
    end

    assign rise = irq_src & ~irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= MASK_RST;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    // Masked lines still latch into pending; they are only kept from selection.
    assign eligible = pending & ~mask;

    prio_enc8_sel u_sel (
        .req       (eligible),
        .idx       (sel_idx),
        .any_valid (sel_any)
    );

    assign accept = (state == PRESENT) && vec_ready;
    assign clr    = accept ? idx_onehot(vec_idx) : '0;

    // Clear before set: a new edge on the line being accepted keeps it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // vec_idx is loaded only on leaving IDLE, so it stays frozen while offered.
    always_comb begin
        state_next   = state;
        vec_idx_next = vec_idx;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_next   = PRESENT;
                    vec_idx_next = sel_idx;
                end
            end
            PRESENT: begin
                if (vec_ready) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from flops, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            vec_idx   <= '0;
        end else begin
            vec_valid <= (state_next == PRESENT);
            busy      <= (state_next == SERVICE);
            vec_idx   <= vec_idx_next;
        end
    end

endmodule
